// File: rtl/mux_scan_n_pkg.sv
// Shared types and constants for the scanning channel multiplexer.
// Also provides the select-width helper used by the interface and top.
package mux_scan_pkg;
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_t;

   // Channel-id width; a single channel still needs a 1-bit select.
   function automatic int selw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mux_scan_n_if.sv
// Control/data bundle between a source bank and the scanning multiplexer.
interface mux_scan_n_if
   import mux_scan_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 1,
   parameter int SELW = selw(N_CH)
);
   logic              en;
   logic              mode;
   logic [SELW-1:0]   sel;
   logic [N_CH-1:0]   mask;
   logic [N_CH*W-1:0] din;
   logic [W-1:0]      dout;
   logic [SELW-1:0]   ch;
   logic              strobe;
   logic              none_active;

   modport master (output en, mode, sel, mask, din,
                   input  dout, ch, strobe, none_active);
   modport slave  (input  en, mode, sel, mask, din,
                   output dout, ch, strobe, none_active);
endinterface

// File: rtl/mux_scan_n_rr_next_sel.sv
// Round-robin successor search: lowest set mask bit strictly above cur,
// wrapping to the lowest set bit overall; returns cur's own index if it is the only one set.
module rr_next_sel #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] cur,
   output logic [IW-1:0] nxt,
   output logic          any_set
);
   logic [IW-1:0] lo, hi;
   logic          found;

   // Descending walk: the last hit is the lowest qualifying index.
   always_comb begin
      lo    = '0;
      hi    = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lo = IW'(i);
            if (i > int'(cur)) begin
               hi    = IW'(i);
               found = 1'b1;
            end
         end
      end
      any_set = |mask;
      nxt     = found ? hi : lo;
   end
endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered mux with manual select or dwell-timed auto-scan
// over unmasked channels; strobes whenever the output channel changes.
module mux_scan_n
   import mux_scan_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int W     = 1,
   parameter int DWELL = 4
) (
   input logic        clk,
   input logic        rst_n,
   mux_scan_n_if.slave bus
);
   localparam int SELW = selw(N_CH);
   localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SELW-1:0] ch_q, ch_d, nxt_ch;
   logic [W-1:0]    dout_q, dout_d;
   logic            strobe_q, strobe_d, none_q, none_d;
   logic            any_set, cur_masked, advance, mode_chg;
   logic [W-1:0]    chan [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_slice
      assign chan[k] = bus.din[k*W +: W];
   end

   rr_next_sel #(.N(N_CH), .IW(SELW)) u_next (
      .mask    (bus.mask),
      .cur     (ch_q),
      .nxt     (nxt_ch),
      .any_set (any_set)
   );

   // An out-of-range channel left over from manual mode counts as masked.
   assign cur_masked = (int'(ch_q) >= N_CH) || !bus.mask[ch_q];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ch_d     = ch_q;
      dout_d   = dout_q;
      none_d   = none_q;
      strobe_d = 1'b0;
      mode_chg = 1'b0;
      advance  = 1'b0;
      if (bus.en) begin
         state_d  = (bus.mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
         mode_chg = (state_d != state_q);
         if (state_d == ST_MANUAL) begin
            ch_d   = bus.sel;
            cnt_d  = '0;
            none_d = 1'b0;
         end else if (!any_set) begin
            cnt_d  = '0;
            none_d = 1'b1;
         end else begin
            none_d  = 1'b0;
            // The entry edge restarts the dwell rather than counting toward it.
            advance = cur_masked || (!mode_chg && cnt_q == CNT_LAST);
            if (advance) ch_d = nxt_ch;
            cnt_d = (advance || mode_chg) ? '0 : cnt_q + 1'b1;
         end
         dout_d = (int'(ch_d) < N_CH) ? chan[ch_d] : '0;
         if (state_d == ST_SCAN && !any_set) dout_d = '0;
         strobe_d = (ch_d != ch_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_MANUAL;
         cnt_q    <= '0;
         ch_q     <= '0;
         dout_q   <= '0;
         strobe_q <= 1'b0;
         none_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ch_q     <= ch_d;
         dout_q   <= dout_d;
         strobe_q <= strobe_d;
         none_q   <= none_d;
      end
   end

   assign bus.dout        = dout_q;
   assign bus.ch          = ch_q;
   assign bus.strobe      = strobe_q;
   assign bus.none_active = none_q;
endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n (N_CH=4, W=1, DWELL=4): vector table plus
// hand sequences for clock-enable freeze and asynchronous reset mid-scan.
module tb_mux_scan_n;
   logic clk, rst_n;
   int   errors = 0;
   int   checks = 0;

   mux_scan_n_if #(.N_CH(4), .W(1)) bus ();

   mux_scan_n #(.N_CH(4), .W(1), .DWELL(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       mode;
      logic [1:0] sel;
      logic [3:0] mask;
      logic [3:0] din;
      logic       dout;
      logic [1:0] ch;
      logic       strobe;
      logic       none;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic en, input logic mode, input int sel,
                               input logic [3:0] mask, input logic [3:0] din,
                               input logic dout, input int ch, input logic strobe,
                               input logic none);
      vec_t v;
      v.en = en; v.mode = mode; v.sel = 2'(sel); v.mask = mask; v.din = din;
      v.dout = dout; v.ch = 2'(ch); v.strobe = strobe; v.none = none;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic dout, input int ch,
                          input logic strobe, input logic none);
      chk({tag, ".dout"},   int'(bus.dout),        int'(dout));
      chk({tag, ".ch"},     int'(bus.ch),          ch);
      chk({tag, ".strobe"}, int'(bus.strobe),      int'(strobe));
      chk({tag, ".none"},   int'(bus.none_active), int'(none));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] d;
      // Manual sweep over din=0110.
      add(1, 0, 0, 4'b0000, 4'b0110, 0, 0, 1, 0);
      add(1, 0, 1, 4'b0000, 4'b0110, 1, 1, 1, 0);
      add(1, 0, 2, 4'b0000, 4'b0110, 1, 2, 1, 0);
      add(1, 0, 3, 4'b1111, 4'b0110, 0, 3, 1, 0);
      add(1, 0, 3, 4'b1111, 4'b0110, 0, 3, 0, 0);
      add(1, 0, 0, 4'b1111, 4'b0110, 0, 0, 1, 0);
      // Full rotation, all unmasked, 4 cycles per channel, then wrap to 0.
      d = 4'b0110;
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 4; k++)
            add(1, 1, 0, 4'b1111, d, d[c], c, (k == 0 && c != 0), 0);
      add(1, 1, 0, 4'b1111, d, 0, 0, 1, 0);
      // Mask 1010: ch0 masked so jump to 1 at once, then 3, then wrap to 1.
      for (int k = 0; k < 4; k++) add(1, 1, 0, 4'b1010, d, 1, 1, k == 0, 0);
      for (int k = 0; k < 4; k++) add(1, 1, 0, 4'b1010, d, 0, 3, k == 0, 0);
      add(1, 1, 0, 4'b1010, d, 1, 1, 1, 0);
      // Nothing enabled: output zeroed, channel held.
      add(1, 1, 0, 4'b0000, d, 0, 1, 0, 1);
      add(1, 1, 0, 4'b0000, d, 0, 1, 0, 1);
      // Only the current channel enabled: never moves, never strobes.
      for (int k = 0; k < 5; k++) add(1, 1, 0, 4'b0010, d, 1, 1, 0, 0);

      // Reset state.
      rst_n = 1'b0;
      bus.en = 1'b1; bus.mode = 1'b0; bus.sel = 2'd1; bus.mask = 4'b0000;
      bus.din = 4'b1010;
      step();
      step();
      chk_out("reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      step();
      chk_out("post_reset", 1, 1, 1, 0);

      foreach (vq[i]) begin
         bus.en = vq[i].en; bus.mode = vq[i].mode; bus.sel = vq[i].sel;
         bus.mask = vq[i].mask; bus.din = vq[i].din;
         step();
         chk_out($sformatf("vec%0d", i), vq[i].dout, int'(vq[i].ch), vq[i].strobe, vq[i].none);
      end

      // Clock-enable freeze: strobe drops, counter and dout hold.
      bus.mode = 1'b0; bus.sel = 2'd2; bus.mask = 4'b1111; bus.din = 4'b0110;
      step();
      chk_out("man_sel2", 1, 2, 1, 0);
      bus.en = 1'b0;
      step();
      chk_out("en0_strobe", 1, 2, 0, 0);
      bus.en = 1'b1; bus.mode = 1'b1;
      step();
      chk_out("scan_entry", 1, 2, 0, 0);
      step();
      chk_out("scan_cnt1", 1, 2, 0, 0);
      bus.en = 1'b0; bus.din = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_out($sformatf("freeze%0d", k), 1, 2, 0, 0);
      end
      bus.en = 1'b1;
      step();
      chk_out("resume_cnt2", 0, 2, 0, 0);
      step();
      chk_out("resume_cnt3", 0, 2, 0, 0);
      step();
      chk_out("resume_adv", 1, 3, 1, 0);

      // Mask only ch2 while at ch3: wrap to 2, then reset between edges.
      bus.mask = 4'b0100; bus.din = 4'b1111;
      step();
      chk_out("mask_wrap_to2", 1, 2, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_out("async_reset", 0, 0, 0, 0);
      bus.mode = 1'b0; bus.sel = 2'd1;
      #2 rst_n = 1'b1;
      step();
      chk_out("after_release", 1, 1, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
